// File: rtl/fcpu_pkg.sv
// Shared fcpu types: widths, opcodes, opcode-class helpers and the
// memory access controller state enum.
package fcpu_pkg;

  localparam int DATA_W   = 32;
  localparam int RSV_ID_W = 4;
  localparam int INSTR_W  = 6;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  localparam logic [INSTR_W-1:0] I_NOP    = 6'h00;
  localparam logic [INSTR_W-1:0] I_LOAD   = 6'h01;
  localparam logic [INSTR_W-1:0] I_LOADB  = 6'h02;
  localparam logic [INSTR_W-1:0] I_LOADR  = 6'h03;
  localparam logic [INSTR_W-1:0] I_STORE  = 6'h04;
  localparam logic [INSTR_W-1:0] I_STOREB = 6'h05;
  localparam logic [INSTR_W-1:0] I_STORER = 6'h06;
  localparam logic [INSTR_W-1:0] I_INPUT  = 6'h07;
  localparam logic [INSTR_W-1:0] I_OUTPUT = 6'h08;
  localparam logic [INSTR_W-1:0] I_ADD    = 6'h09;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAIT,
    S_RX_WAIT,
    S_TX_WAIT,
    S_RESP
  } mac_state_t;

  function automatic logic is_read(input logic [INSTR_W-1:0] op);
    return (op == I_LOAD) || (op == I_LOADB) || (op == I_LOADR);
  endfunction

  function automatic logic is_write(input logic [INSTR_W-1:0] op);
    return (op == I_STORE) || (op == I_STOREB) || (op == I_STORER);
  endfunction

  function automatic logic is_in(input logic [INSTR_W-1:0] op);
    return op == I_INPUT;
  endfunction

  function automatic logic is_out(input logic [INSTR_W-1:0] op);
    return op == I_OUTPUT;
  endfunction

endpackage

// File: rtl/memory_access_controller_if.sv
// MFU request, BRAM port, UART streams and CDB result bundle of the
// memory access controller.
interface memory_access_controller_if
  import fcpu_pkg::*;
#(
  parameter int ADDR_W = 16
);
  logic                req_valid;
  logic [INSTR_W-1:0]  req_opcode;
  logic [RSV_ID_W-1:0] req_rsv_id;
  logic [DATA_W-1:0]   req_address;
  logic [DATA_W-1:0]   req_data;
  logic                req_ready;

  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                rx_ready;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_ready;

  logic [CDB_W-1:0]    o_cdb;
  logic                o_cdb_valid;
  logic                o_cdb_ready;
  logic                range_err;

  modport slave (
    input  req_valid, req_opcode, req_rsv_id,
    input  req_address, req_data,
    output req_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    input  rx_valid, rx_data,
    output rx_ready,
    output tx_valid, tx_data,
    input  tx_ready,
    output o_cdb, o_cdb_valid,
    input  o_cdb_ready,
    output range_err
  );

  modport master (
    output req_valid, req_opcode, req_rsv_id,
    output req_address, req_data,
    input  req_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    output rx_valid, rx_data,
    input  rx_ready,
    input  tx_valid, tx_data,
    output tx_ready,
    input  o_cdb, o_cdb_valid,
    output o_cdb_ready,
    input  range_err
  );

endinterface

// File: rtl/memory_access_controller.sv
// Sequences BRAM and UART accesses for the MFU, one at a time.
// FCPU_MEM_RANGE_CHECK_EN enables out-of-range address trapping.
module memory_access_controller
  import fcpu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input logic clk,
  input logic nrst,
  memory_access_controller_if.slave bus
);

  mac_state_t          state_q, state_d;
  logic [RSV_ID_W-1:0] tag_q, tag_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [CDB_W-1:0]    cdb_q, cdb_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                oor_rd_q, oor_rd_d;
  logic                range_err_q, range_err_d;

  logic req_ready, accept, oor, mem_go;
  logic op_rd, op_wr, op_in, op_out;

  assign op_rd  = is_read(bus.req_opcode);
  assign op_wr  = is_write(bus.req_opcode);
  assign op_in  = is_in(bus.req_opcode);
  assign op_out = is_out(bus.req_opcode);

`ifdef FCPU_MEM_RANGE_CHECK_EN
  assign oor = |bus.req_address[DATA_W-1:ADDR_W];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_address[DATA_W-1:ADDR_W];
  assign oor = 1'b0;
`endif

  assign req_ready = (state_q == S_IDLE) && !nrst;
  assign accept    = bus.req_valid && req_ready;
  assign mem_go    = accept && (op_rd || op_wr) && !oor;

  assign bus.req_ready = req_ready;
  assign bus.mem_en    = mem_go;
  assign bus.mem_we    = mem_go && op_wr;
  assign bus.mem_addr  = mem_go ? bus.req_address[ADDR_W-1:0] : '0;
  assign bus.mem_wdata = (mem_go && op_wr) ? bus.req_data : '0;

  assign bus.rx_ready    = (state_q == S_RX_WAIT) && !nrst;
  assign bus.tx_valid    = tx_valid_q && !nrst;
  assign bus.tx_data     = tx_data_q;
  assign bus.o_cdb       = cdb_q;
  assign bus.o_cdb_valid = cdb_valid_q && !nrst;
  assign bus.range_err   = range_err_q;

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    cdb_d       = cdb_q;
    cdb_valid_d = cdb_valid_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    oor_rd_d    = oor_rd_q;
    range_err_d = range_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          range_err_d = range_err_q | ((op_rd | op_wr) & oor);
          unique case (1'b1)
            op_rd: begin
              tag_d    = bus.req_rsv_id;
              cnt_d    = 3'(MEM_LATENCY);
              oor_rd_d = oor;
              state_d  = S_READ_WAIT;
            end
            op_in: begin
              tag_d   = bus.req_rsv_id;
              state_d = S_RX_WAIT;
            end
            op_out: begin
              tx_valid_d = 1'b1;
              tx_data_d  = bus.req_data[7:0];
              state_d    = S_TX_WAIT;
            end
            default: ;
          endcase
        end
      end
      S_READ_WAIT: begin
        // cnt_q==1 marks the cycle mem_rdata is valid
        if (cnt_q == 3'd1) begin
          cnt_d       = '0;
          cdb_d       = {tag_q, oor_rd_q ? '0 : bus.mem_rdata};
          cdb_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RX_WAIT: begin
        if (bus.rx_valid) begin
          cdb_d       = {tag_q, 24'd0, bus.rx_data};
          cdb_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_TX_WAIT: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_RESP: begin
        if (bus.o_cdb_ready) begin
          cdb_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q     <= S_IDLE;
      tag_q       <= '0;
      cnt_q       <= '0;
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      oor_rd_q    <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      cdb_q       <= cdb_d;
      cdb_valid_q <= cdb_valid_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      oor_rd_q    <= oor_rd_d;
      range_err_q <= range_err_d;
    end
  end

endmodule

// File: tb/tb_memory_access_controller.sv
// Randomized self-checking bench for memory_access_controller against
// a word-addressed memory map and UART transaction model.
module tb_memory_access_controller;
  import fcpu_pkg::*;

  localparam int LAT = 3;
  localparam int AW  = 16;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  memory_access_controller_if #(.ADDR_W(AW)) bus ();

  memory_access_controller #(
    .ADDR_W(AW),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus)
  );

  // BRAM device with LAT-cycle read latency; garbage when not enabled
  logic [DATA_W-1:0] bram [64];
  logic [DATA_W-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) bram[bus.mem_addr[5:0]] <= bus.mem_wdata;
      pipe[0] <= bram[bus.mem_addr[5:0]];
    end else begin
      pipe[0] <= 32'hBAD0BAD0;
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[LAT-1];

  logic [DATA_W-1:0] ref_mem [int];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_range(input logic [31:0] a);
`ifdef FCPU_MEM_RANGE_CHECK_EN
    return a[31:AW] == '0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [31:0] a);
    int k;
    k = int'(a[AW-1:0]);
    if (!in_range(a)) return '0;
    return ref_mem.exists(k) ? ref_mem[k] : '0;
  endfunction

  task automatic go(input logic [INSTR_W-1:0] op,
                    input logic [RSV_ID_W-1:0] tag,
                    input logic [31:0] addr, input logic [31:0] data);
    bus.req_valid   = 1'b1;
    bus.req_opcode  = op;
    bus.req_rsv_id  = tag;
    bus.req_address = addr;
    bus.req_data    = data;
    #1;
  endtask

  task automatic do_store(input logic [INSTR_W-1:0] op,
                          input logic [31:0] addr, input logic [31:0] data);
    logic ok;
    ok = in_range(addr);
    go(op, '0, addr, data);
    chk("st_ready", bus.req_ready, 1);
    chk("st_en", bus.mem_en, ok);
    chk("st_we", bus.mem_we, ok);
    if (ok) begin
      chk("st_addr", bus.mem_addr, addr[AW-1:0]);
      chk("st_wdata", bus.mem_wdata, data);
      ref_mem[int'(addr[AW-1:0])] = data;
    end
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("st_nocdb", bus.o_cdb_valid, 0);
    chk("st_idle", bus.req_ready, 1);
  endtask

  task automatic do_load(input logic [INSTR_W-1:0] op,
                         input logic [31:0] addr,
                         input logic [RSV_ID_W-1:0] tag, input int bp);
    logic [DATA_W-1:0] exp;
    logic [CDB_W-1:0] held;
    int cyc;
    exp = ref_rd(addr);
    go(op, tag, addr, $urandom);
    chk("ld_ready", bus.req_ready, 1);
    chk("ld_en", bus.mem_en, in_range(addr));
    chk("ld_we", bus.mem_we, 0);
    tick();
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.o_cdb_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("ld_latency", cyc, LAT + 1);
    chk("ld_cdb", bus.o_cdb, {tag, exp});
    held = bus.o_cdb;
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_valid", bus.o_cdb_valid, 1);
      chk("bp_cdb", bus.o_cdb, held);
      chk("bp_ready", bus.req_ready, 0);
    end
    bus.o_cdb_ready = 1'b1;
    tick();
    bus.o_cdb_ready = 1'b0;
    #1;
    chk("ld_done_valid", bus.o_cdb_valid, 0);
    chk("ld_done_idle", bus.req_ready, 1);
  endtask

  task automatic do_input(input logic [RSV_ID_W-1:0] tag, input int dly,
                          input logic early, input logic [7:0] b);
    if (early) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
    end
    go(I_INPUT, tag, $urandom, $urandom);
    chk("in_noready_idle", bus.rx_ready, 0);
    chk("in_en", bus.mem_en, 0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("in_rxready", bus.rx_ready, 1);
    if (!early) begin
      for (int i = 0; i < dly; i++) tick();
      chk("in_rxready_wait", bus.rx_ready, 1);
      chk("in_wait_nocdb", bus.o_cdb_valid, 0);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
    end
    tick();
    bus.rx_valid = 1'b0;
    #1;
    chk("in_rxready_off", bus.rx_ready, 0);
    chk("in_valid", bus.o_cdb_valid, 1);
    chk("in_cdb", bus.o_cdb, {tag, 24'd0, b});
    bus.o_cdb_ready = 1'b1;
    tick();
    bus.o_cdb_ready = 1'b0;
    #1;
    chk("in_idle", bus.req_ready, 1);
  endtask

  task automatic do_output(input logic [31:0] data, input int dly);
    go(I_OUTPUT, '0, $urandom, data);
    chk("out_en", bus.mem_en, 0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("out_valid", bus.tx_valid, 1);
    chk("out_data", bus.tx_data, data[7:0]);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("out_hold_valid", bus.tx_valid, 1);
      chk("out_hold_data", bus.tx_data, data[7:0]);
      chk("out_nocdb", bus.o_cdb_valid, 0);
      chk("out_busy", bus.req_ready, 0);
    end
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    #1;
    chk("out_drop", bus.tx_valid, 0);
    chk("out_idle", bus.req_ready, 1);
  endtask

  task automatic do_other();
    go(I_ADD, 4'hF, $urandom, $urandom);
    chk("oth_en", bus.mem_en, 0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("oth_idle", bus.req_ready, 1);
    chk("oth_nocdb", bus.o_cdb_valid, 0);
    chk("oth_notx", bus.tx_valid, 0);
  endtask

  initial begin
    logic seen;
    int op;
    logic [INSTR_W-1:0] rd_ops [3];
    logic [INSTR_W-1:0] wr_ops [3];
    rd_ops = '{I_LOAD, I_LOADB, I_LOADR};
    wr_ops = '{I_STORE, I_STOREB, I_STORER};
    for (int i = 0; i < 64; i++) bram[i] = '0;
    bus.req_valid = 0; bus.req_opcode = '0; bus.req_rsv_id = '0;
    bus.req_address = '0; bus.req_data = '0;
    bus.rx_valid = 0; bus.rx_data = '0;
    bus.tx_ready = 0; bus.o_cdb_ready = 0;

    tick();
    tick();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_cdb", bus.o_cdb, 0);
    chk("rst_cdb_valid", bus.o_cdb_valid, 0);
    chk("rst_tx", {bus.tx_valid, bus.tx_data}, 0);
    chk("rst_rx_ready", bus.rx_ready, 0);
    chk("rst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    chk("rst_range_err", bus.range_err, 0);
    nrst = 1'b0;
    #1;
    chk("rel_req_ready", bus.req_ready, 1);

    do_store(I_STORE, 32'h10, 32'hDEADBEEF);
    do_load(I_LOAD, 32'h10, 4'd5, 0);
    do_store(I_STORE, 32'h11, 32'h0BADF00D);
    do_store(I_STOREB, 32'h12, 32'h13572468);
    do_load(I_LOADR, 32'h11, 4'd3, 4);
    do_input(4'd7, 10, 1'b0, 8'h41);
    do_input(4'd6, 0, 1'b1, 8'hA5);
    do_output(32'h12345678, 3);
    do_other();

    go(I_LOAD, 4'd9, 32'h10, '0);
    tick();
    bus.req_valid = 1'b0;
    nrst = 1'b1;
    #1;
    chk("mid_rst_ready", bus.req_ready, 0);
    chk("mid_rst_valid", bus.o_cdb_valid, 0);
    tick();
    chk("mid_rst_cdb", bus.o_cdb, 0);
    chk("mid_rst_tx", {bus.tx_valid, bus.tx_data}, 0);
    chk("mid_rst_mem", {bus.mem_en, bus.mem_we}, 0);
    nrst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      seen |= bus.o_cdb_valid;
    end
    chk("mid_rst_silent", seen, 0);
    chk("mid_rst_idle", bus.req_ready, 1);

    chk("range_err_clear", bus.range_err, 0);
`ifdef FCPU_MEM_RANGE_CHECK_EN
    do_load(I_LOAD, 32'h0001_0000, 4'd2, 0);
    chk("range_err_set", bus.range_err, 1);
    do_store(I_STORE, 32'h0001_0000, 32'hCAFEBABE);
    chk("range_err_sticky", bus.range_err, 1);
`else
    do_load(I_LOAD, 32'h0001_0010, 4'd2, 0);
    chk("range_err_tied", bus.range_err, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: do_store(wr_ops[$urandom_range(0, 2)],
                       32'($urandom_range(0, 63)), $urandom);
        2: do_load(rd_ops[$urandom_range(0, 2)],
                   32'($urandom_range(0, 63)),
                   4'($urandom_range(0, 15)), $urandom_range(0, 3));
        3: do_input(4'($urandom_range(0, 15)), $urandom_range(0, 5),
                    1'($urandom_range(0, 1)), 8'($urandom));
        4: do_output($urandom, $urandom_range(0, 3));
        default: do_other();
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_access_controller.md
Name: memory_access_controller

Overview:
- Sequences the single data-memory port and the UART byte streams on behalf of the memory functional unit.
- Accepts one issued access at a time (o_valid/o_opcode/o_rsv_id/o_address/o_data of the MFU) and drives the synchronous BRAM port or the UART.
- Returns load/input results to the CDB arbiter as {rsv_id, data} words.
- Sits between the MFU and the memory/IO fabric.

Parameters:
- ADDR_W, 16, BRAM word-address width; mem_addr = req_address[ADDR_W-1:0].
- MEM_LATENCY, 1, cycles from mem_en high to valid mem_rdata; legal range 1..7.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, synchronous, active-high.
- req_valid  in  1  access request.
- req_opcode  in  INSTR_W  fcpu_pkg opcode.
- req_rsv_id  in  RSV_ID_W  ROB tag of the access.
- req_address  in  DATA_W  effective address.
- req_data  in  DATA_W  store/output data.
- req_ready  out  1  request accepted when req_valid&req_ready.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data.
- rx_valid  in  1  UART RX byte available.
- rx_data  in  8  UART RX byte.
- rx_ready  out  1  RX byte consumed.
- tx_valid  out  1  UART TX byte valid.
- tx_data  out  8  UART TX byte.
- tx_ready  in  1  UART TX accepts.
- o_cdb  out  CDB_W  {rsv_id, data}.
- o_cdb_valid  out  1  result valid.
- o_cdb_ready  in  1  CDB arbiter accepts.
- range_err  out  1  sticky out-of-range flag (optional feature).

Behaviour:
- Opcode classes:
  - READ = I_LOAD, I_LOADB, I_LOADR.
  - WRITE = I_STORE, I_STOREB, I_STORER.
  - IN = I_INPUT.
  - OUT = I_OUTPUT.
  - Any other opcode is accepted and discarded with no side effect.
- FSM states: IDLE, READ_WAIT, RX_WAIT, TX_WAIT, RESP.
- req_ready = (state==IDLE).
- mem_en, mem_we, mem_addr and mem_wdata are combinational from the accepted request, and are zero when no access is accepted.
- WRITE:
  - Acceptance cycle drives mem_en=1, mem_we=1, address and data.
  - State stays IDLE, so back-to-back stores issue every cycle.
  - No CDB result is produced.
- READ:
  - Acceptance cycle drives mem_en=1, mem_we=0.
  - The tag is latched, state goes to READ_WAIT and a latency counter loads MEM_LATENCY.
  - The counter decrements each cycle. In the cycle where mem_rdata is valid (MEM_LATENCY cycles after mem_en), {tag, mem_rdata} is registered and state goes to RESP.
  - o_cdb_valid rises MEM_LATENCY+1 cycles after acceptance.
- IN:
  - Acceptance latches the tag and goes to RX_WAIT.
  - In RX_WAIT, rx_ready=1. On rx_valid, {tag, zero-extended rx_data} is registered and state goes to RESP.
  - Waits indefinitely for a byte.
- OUT:
  - Acceptance registers tx_data=req_data[7:0] and sets tx_valid=1, then goes to TX_WAIT.
  - tx_valid and tx_data are held stable until tx_ready, then tx_valid=0 and state returns to IDLE.
  - No CDB result is produced.
- RESP:
  - o_cdb_valid=1 and o_cdb is held stable until o_cdb_ready.
  - On that handshake, state returns to IDLE.
  - A new request is accepted no earlier than the next cycle.
- Reset values (while nrst=1 and after it, until the next event):
  - state=IDLE, all counters 0.
  - o_cdb=0, o_cdb_valid=0, tx_valid=0, tx_data=0, rx_ready=0, range_err=0, mem_* = 0.
  - req_ready=0 while nrst=1.
- Reset asserted mid-operation aborts immediately: any pending result, TX byte and RX wait are dropped, and nothing is emitted afterwards.
- Simultaneous rx_valid on entering RX_WAIT: rx_ready is asserted only from the first RX_WAIT cycle onward; no byte is consumed in IDLE.
- MEM_LATENCY=1: READ_WAIT lasts exactly one cycle.

Optional Feature:
- Macro: FCPU_MEM_RANGE_CHECK_EN.
- Defined: a READ/WRITE whose req_address[DATA_W-1:ADDR_W] is nonzero is out of range.
  - Out-of-range WRITE: mem_en=0, the store is dropped.
  - Out-of-range READ: mem_en=0 and the result is {tag, 0}, with identical timing (MEM_LATENCY+1).
  - range_err sets sticky until reset.
- Undefined: the address is silently truncated to ADDR_W bits and range_err is tied 0.

Decomposition:
- Opcode class function is_read/is_write/is_in/is_out goes in fcpu_pkg, shared with the MFU.
- The state enum mac_state_t goes in fcpu_pkg.
- CDB_W, DATA_W, RSV_ID_W and INSTR_W already live in fcpu_pkg.
- No sub-module; the latency counter is inline.

Test Plan:
- Store then load: STORE addr 0x10 data 0xDEADBEEF, next cycle LOAD addr 0x10 tag 5 -> mem_we pulse, then o_cdb={5,0xDEADBEEF} valid exactly MEM_LATENCY+1 cycles after load acceptance.
- CDB backpressure: LOAD tag 3, hold o_cdb_ready=0 for 4 cycles -> o_cdb stable, req_ready=0 throughout, IDLE one cycle after handshake.
- INPUT: INPUT tag 7, rx_valid delayed 10 cycles with rx_data 0x41 -> rx_ready high from RX_WAIT, o_cdb={7,0x00000041}.
- OUTPUT: OUTPUT data 0x12345678, tx_ready low for 3 cycles -> tx_valid held with tx_data 0x78, no CDB output.
- Reset mid-read: LOAD accepted, nrst=1 during READ_WAIT -> no o_cdb_valid ever, all outputs 0, req_ready=1 after release.
- With FCPU_MEM_RANGE_CHECK_EN, ADDR_W=16: LOAD addr 0x00010000 tag 2 -> mem_en=0, o_cdb={2,0}, range_err=1; STORE to the same address -> no mem_we.
